// File: rtl/cicero_axi_top_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Packages : AXI_package, instruction_package                                |
// | Register map / command codes and the 16-bit instruction format.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package AXI_package;
    localparam int REG_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
    localparam logic [REG_WIDTH-1:0] CMD_READ               = 32'd2;
    localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd3;
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd4;
    localparam logic [REG_WIDTH-1:0] CMD_READ_FIFO_COUNT    = 32'd5;
    localparam logic [REG_WIDTH-1:0] CMD_READ_CACHE_HITS    = 32'd6;
    localparam logic [REG_WIDTH-1:0] CMD_READ_CACHE_MISS    = 32'd7;

    localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
endpackage

package instruction_package;
    localparam int INSTRUCTION_WIDTH = 16;
    localparam int OPERAND_WIDTH     = 13;

    typedef enum logic [2:0] {
        ACCEPT                = 3'd0,
        SPLIT                 = 3'd1,
        MATCH_CHAR            = 3'd2,
        JMP                   = 3'd3,
        END_WITHOUT_ACCEPTING = 3'd4,
        MATCH_ANY             = 3'd5,
        ACCEPT_PARTIAL        = 3'd6,
        NOT_MATCH             = 3'd7
    } opcode_e;

    // Two instructions share a code word; odd indices live in the upper half.
    function automatic logic [INSTRUCTION_WIDTH-1:0] select_half(
        input logic [2*INSTRUCTION_WIDTH-1:0] word,
        input logic                           upper
    );
        return upper ? word[2*INSTRUCTION_WIDTH-1:INSTRUCTION_WIDTH]
                     : word[INSTRUCTION_WIDTH-1:0];
    endfunction
endpackage
`default_nettype wire

// File: rtl/cicero_axi_top_thread_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cicero_thread_fifo                                              |
// | Queue of pending backtrack threads {pc, cc} with occupancy and peak.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cicero_thread_fifo #(
    parameter int CC_ID_BITS = 2,
    parameter int PC_WIDTH   = 13,
    parameter int CC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_push,
    input  logic [PC_WIDTH-1:0] i_push_pc,
    input  logic [CC_WIDTH-1:0] i_push_cc,
    input  logic                i_pop,
    output logic [PC_WIDTH-1:0] o_pop_pc,
    output logic [CC_WIDTH-1:0] o_pop_cc,
    output logic                o_empty,
    output logic                o_full,
    output logic [CC_ID_BITS:0] o_count,
    output logic [CC_ID_BITS:0] o_peak
);
    localparam int                c_depth     = 2**CC_ID_BITS;
    localparam logic [CC_ID_BITS:0] c_full_cnt = {1'b1, {CC_ID_BITS{1'b0}}};

    logic [PC_WIDTH+CC_WIDTH-1:0] r_mem [c_depth];
    logic [CC_ID_BITS-1:0]        r_wr_ptr;
    logic [CC_ID_BITS-1:0]        r_rd_ptr;
    logic [CC_ID_BITS:0]          r_count;
    logic [CC_ID_BITS:0]          r_peak;
    logic [CC_ID_BITS:0]          w_count_nxt;
    logic                         w_do_push;
    logic                         w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full_cnt);
    assign o_count   = r_count;
    assign o_peak    = r_peak;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign {o_pop_pc, o_pop_cc} = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= {i_push_pc, i_push_cc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_peak   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            if (w_count_nxt > r_peak) begin
                r_peak <= w_count_nxt;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/cicero_axi_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cicero_axi_top                                                  |
// | Register-driven single-engine backtracking regex co-processor.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cicero_axi_top
    import AXI_package::*;
    import instruction_package::*;
#(
    parameter int BB_N       = 1,
    parameter int CC_ID_BITS = 2,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] data_in_register,
    input  logic [REG_WIDTH-1:0] address_register,
    input  logic [REG_WIDTH-1:0] start_cc_pointer_register,
    input  logic [REG_WIDTH-1:0] end_cc_pointer_register,
    input  logic [REG_WIDTH-1:0] cmd_register,
    output logic [REG_WIDTH-1:0] status_register,
    output logic [REG_WIDTH-1:0] data_o_register
);
    localparam int c_addr_w = $clog2(MEM_WORDS);
    localparam int c_pc_w   = OPERAND_WIDTH;

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_FETCH      = 3'd1;
    localparam logic [2:0] c_ST_FETCH_WAIT = 3'd2;
    localparam logic [2:0] c_ST_EXEC       = 3'd3;
    localparam logic [2:0] c_ST_CHAR       = 3'd4;

    generate
        if (BB_N != 1) begin : g_bb_n_illegal
            $error("cicero_axi_top supports exactly one engine (BB_N must be 1)");
        end
    endgenerate

    logic [REG_WIDTH-1:0]         r_mem [MEM_WORDS];
    logic [REG_WIDTH-1:0]         r_eng_rdata;
    logic [REG_WIDTH-1:0]         r_data_o;
    logic [REG_WIDTH-1:0]         r_status;
    logic [2:0]                   r_state;
    logic [2:0]                   w_state_nxt;
    logic [c_pc_w-1:0]            r_pc;
    logic [c_pc_w-1:0]            w_pc_nxt;
    logic [REG_WIDTH-1:0]         r_cc;
    logic [REG_WIDTH-1:0]         w_cc_nxt;
    logic [REG_WIDTH-1:0]         r_end;
    logic [REG_WIDTH-1:0]         r_ibuf;
    logic [c_pc_w-2:0]            r_ibuf_idx;
    logic                         r_ibuf_valid;
    logic [REG_WIDTH-1:0]         r_elapsed;
    logic [REG_WIDTH-1:0]         r_hits;
    logic [REG_WIDTH-1:0]         r_misses;

    logic                         w_running;
    logic                         w_start;
    logic                         w_host_we;
    logic [c_addr_w-1:0]          w_host_addr;
    logic [c_addr_w-1:0]          w_eng_addr;
    logic [c_pc_w-2:0]            w_pc_word;
    logic [INSTRUCTION_WIDTH-1:0] w_instr;
    opcode_e                      w_op;
    logic [OPERAND_WIDTH-1:0]     w_operand;
    logic [7:0]                   w_char;
    logic                         w_cc_in_range;
    logic                         w_cc_past_end;
    logic                         w_char_ok;
    logic                         w_hit;
    logic                         w_miss;
    logic                         w_refill;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_kill;
    logic                         w_accept;
    logic                         w_reject;
    logic                         w_sel_zero;
    logic [c_pc_w-1:0]            w_fifo_pc;
    logic [REG_WIDTH-1:0]         w_fifo_cc;
    logic                         w_fifo_empty;
    logic                         w_fifo_full;
    logic [CC_ID_BITS:0]          w_fifo_count;
    logic [CC_ID_BITS:0]          w_fifo_peak;
    logic                         w_unused_addr;

    assign w_running     = (r_status == STATUS_RUNNING);
    assign w_start       = (cmd_register == CMD_START) && (r_state == c_ST_IDLE);
    assign w_host_we     = !rst && (cmd_register == CMD_WRITE) && !w_running;
    assign w_host_addr   = address_register[c_addr_w-1:0];
    assign w_unused_addr = ^address_register[REG_WIDTH-1:c_addr_w];
    assign w_sel_zero    = (data_in_register == '0);

    assign w_pc_word     = r_pc[c_pc_w-1:1];
    assign w_instr       = select_half(r_ibuf, r_pc[0]);
    assign w_op          = opcode_e'(w_instr[INSTRUCTION_WIDTH-1:OPERAND_WIDTH]);
    assign w_operand     = w_instr[OPERAND_WIDTH-1:0];
    assign w_char        = r_eng_rdata[{r_cc[1:0], 3'b000} +: 8];
    assign w_cc_in_range = (r_cc <= r_end);
    assign w_cc_past_end = ({1'b0, r_cc} == ({1'b0, r_end} + 33'd1));
    assign w_char_ok     = (w_char == w_operand[7:0]) != (w_op == NOT_MATCH);

    // The engine port reads the string byte while executing, code otherwise.
    assign w_eng_addr = (r_state == c_ST_EXEC) ? r_cc[c_addr_w+1:2]
                                               : c_addr_w'(w_pc_word);

    assign status_register = r_status;
    assign data_o_register = r_data_o;

    cicero_thread_fifo #(
        .CC_ID_BITS (CC_ID_BITS),
        .PC_WIDTH   (c_pc_w),
        .CC_WIDTH   (REG_WIDTH)
    ) u_thread_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_start),
        .i_push    (w_push),
        .i_push_pc (w_operand),
        .i_push_cc (r_cc),
        .i_pop     (w_pop),
        .o_pop_pc  (w_fifo_pc),
        .o_pop_cc  (w_fifo_cc),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full),
        .o_count   (w_fifo_count),
        .o_peak    (w_fifo_peak)
    );

    always_ff @(posedge clk) begin
        if (w_host_we) begin
            r_mem[w_host_addr] <= data_in_register;
        end
        r_eng_rdata <= r_mem[w_eng_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cc_nxt    = r_cc;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_refill    = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_kill      = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (r_ibuf_valid && (r_ibuf_idx == w_pc_word)) begin
                    w_hit       = 1'b1;
                    w_state_nxt = c_ST_EXEC;
                end else begin
                    w_miss      = 1'b1;
                    w_state_nxt = c_ST_FETCH_WAIT;
                end
            end
            c_ST_FETCH_WAIT: begin
                w_refill    = 1'b1;
                w_state_nxt = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                case (w_op)
                    ACCEPT: begin
                        w_accept = w_cc_past_end;
                        w_kill   = !w_cc_past_end;
                    end
                    SPLIT: begin
                        if (w_fifo_full) begin
                            w_reject = 1'b1;
                        end else begin
                            w_push      = 1'b1;
                            w_pc_nxt    = r_pc + 1'b1;
                            w_state_nxt = c_ST_FETCH;
                        end
                    end
                    MATCH_CHAR, NOT_MATCH: begin
                        if (w_cc_in_range) begin
                            w_state_nxt = c_ST_CHAR;
                        end else begin
                            w_kill = 1'b1;
                        end
                    end
                    MATCH_ANY: begin
                        if (w_cc_in_range) begin
                            w_pc_nxt    = r_pc + 1'b1;
                            w_cc_nxt    = r_cc + 32'd1;
                            w_state_nxt = c_ST_FETCH;
                        end else begin
                            w_kill = 1'b1;
                        end
                    end
                    JMP: begin
                        w_pc_nxt    = w_operand;
                        w_state_nxt = c_ST_FETCH;
                    end
                    ACCEPT_PARTIAL: w_accept = 1'b1;
                    default:        w_kill   = 1'b1;
                endcase
            end
            c_ST_CHAR: begin
                if (w_char_ok) begin
                    w_pc_nxt    = r_pc + 1'b1;
                    w_cc_nxt    = r_cc + 32'd1;
                    w_state_nxt = c_ST_FETCH;
                end else begin
                    w_kill = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase

        // A dead thread resumes the oldest pending alternative, if any.
        if (w_kill) begin
            if (w_fifo_empty) begin
                w_reject = 1'b1;
            end else begin
                w_pop       = 1'b1;
                w_pc_nxt    = w_fifo_pc;
                w_cc_nxt    = w_fifo_cc;
                w_state_nxt = c_ST_FETCH;
            end
        end
        if (w_accept || w_reject) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status     <= STATUS_IDLE;
            r_pc         <= '0;
            r_cc         <= '0;
            r_end        <= '0;
            r_ibuf       <= '0;
            r_ibuf_idx   <= '0;
            r_ibuf_valid <= 1'b0;
            r_elapsed    <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
        end else if (w_start) begin
            r_status     <= STATUS_RUNNING;
            r_pc         <= '0;
            r_cc         <= start_cc_pointer_register;
            r_end        <= end_cc_pointer_register;
            r_ibuf_valid <= 1'b0;
            r_elapsed    <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            r_cc <= w_cc_nxt;
            if (w_accept) begin
                r_status <= STATUS_ACCEPTED;
            end else if (w_reject) begin
                r_status <= STATUS_REJECTED;
            end
            if (w_refill) begin
                r_ibuf       <= r_eng_rdata;
                r_ibuf_idx   <= w_pc_word;
                r_ibuf_valid <= 1'b1;
            end
            if (w_hit) begin
                r_hits <= r_hits + 32'd1;
            end
            if (w_miss) begin
                r_misses <= r_misses + 32'd1;
            end
            if (w_running && (r_elapsed != '1)) begin
                r_elapsed <= r_elapsed + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_o <= '0;
        end else begin
            case (cmd_register)
                CMD_READ:               r_data_o <= r_mem[w_host_addr];
                CMD_READ_ELAPSED_CLOCK: r_data_o <= r_elapsed;
                CMD_READ_FIFO_COUNT:    r_data_o <= w_sel_zero ? REG_WIDTH'(w_fifo_peak) : '0;
                CMD_READ_CACHE_HITS:    r_data_o <= w_sel_zero ? r_hits : '0;
                CMD_READ_CACHE_MISS:    r_data_o <= w_sel_zero ? r_misses : '0;
                default:                r_data_o <= r_data_o;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cicero_axi_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cicero_axi_top                                               |
// | Directed-vector scoreboard bench for cicero_axi_top.                       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_cicero_axi_top;
    import AXI_package::*;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in_register          = '0;
    logic [31:0] address_register          = '0;
    logic [31:0] start_cc_pointer_register = '0;
    logic [31:0] end_cc_pointer_register   = '0;
    logic [31:0] cmd_register              = CMD_NOP;
    logic [31:0] status_register;
    logic [31:0] data_o_register;

    exp_t        q_data[$];
    exp_t        q_status[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          tb_rd = 1'b0;
    bit          tb_st = 1'b0;
    int          run_cycles = 0;
    int          last_run = 0;
    logic [31:0] prev_status = STATUS_IDLE;

    cicero_axi_top #(
        .BB_N       (1),
        .CC_ID_BITS (2),
        .MEM_WORDS  (1024)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .data_in_register          (data_in_register),
        .address_register          (address_register),
        .start_cc_pointer_register (start_cc_pointer_register),
        .end_cc_pointer_register   (end_cc_pointer_register),
        .cmd_register              (cmd_register),
        .status_register           (status_register),
        .data_o_register           (data_o_register)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: data_o is presented the cycle after a read command, status
    // whenever the engine leaves RUNNING (or on an explicit probe).
    initial begin : monitor
        bit   rd_i;
        bit   st_i;
        exp_t e;
        forever begin
            @(posedge clk);
            rd_i = tb_rd;
            st_i = tb_st;
            @(negedge clk);
            if (rd_i) begin
                if (q_data.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL data_o: unexpected result 0x%08h", data_o_register);
                end else begin
                    e = q_data.pop_front();
                    check(e.name, data_o_register, e.exp);
                end
            end
            if (status_register == STATUS_RUNNING) begin
                run_cycles++;
            end else if (prev_status == STATUS_RUNNING || st_i) begin
                if (prev_status == STATUS_RUNNING) begin
                    last_run   = run_cycles;
                    run_cycles = 0;
                end
                if (q_status.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL status: unexpected value 0x%08h", status_register);
                end else begin
                    e = q_status.pop_front();
                    check(e.name, status_register, e.exp);
                end
            end
            prev_status = status_register;
        end
    end

    task automatic drive(input logic [31:0] cmd, input logic [31:0] addr,
                         input logic [31:0] din, input bit rd, input bit st);
        @(posedge clk);
        #1;
        cmd_register     = cmd;
        address_register = addr;
        data_in_register = din;
        tb_rd            = rd;
        tb_st            = st;
    endtask

    task automatic idle();
        drive(CMD_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        drive(CMD_WRITE, addr, data, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] cmd, input logic [31:0] addr, input logic [31:0] sel,
                      input string name, input logic [31:0] exp);
        q_data.push_back('{name, exp});
        drive(cmd, addr, sel, 1'b1, 1'b0);
    endtask

    task automatic start_run(input logic [31:0] s, input logic [31:0] e,
                             input string name, input logic [31:0] exp_status);
        q_status.push_back('{name, exp_status});
        @(posedge clk);
        #1;
        start_cc_pointer_register = s;
        end_cc_pointer_register   = e;
        cmd_register              = CMD_START;
        tb_rd                     = 1'b0;
        tb_st                     = 1'b0;
    endtask

    task automatic finish_run(input string name, input int max_cycles);
        int n;
        n = 0;
        idle();
        while (status_register == STATUS_RUNNING && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: still RUNNING after %0d cycles, expected completion", name, n);
        end
        idle();
        check({name, "_run_len_ok"}, 32'((last_run >= 2) && (last_run <= max_cycles)), 32'd1);
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        q_status.push_back('{"status_after_reset", STATUS_IDLE});
        q_data.push_back('{"data_o_after_reset", 32'd0});
        drive(CMD_NOP, 32'd0, 32'd0, 1'b1, 1'b1);

        wr(32'd6, 32'h1111_1111);
        wr(32'd5, 32'hDEAD_BEEF);
        rd(CMD_READ, 32'd5, 32'd0, "read_word5", 32'hDEAD_BEEF);
        rd(CMD_READ, 32'd6, 32'd0, "read_word6", 32'h1111_1111);

        // MATCH_CHAR 'a'; ACCEPT -- string "a" at byte 4
        wr(32'd0, 32'h0000_4061);
        wr(32'd1, 32'h0000_0061);
        start_run(32'd4, 32'd4, "status_prog_a", STATUS_ACCEPTED);
        finish_run("prog_a", 8);
        rd(CMD_READ_CACHE_HITS, 32'd0, 32'd0, "hits_prog_a", 32'd1);
        rd(CMD_READ_CACHE_MISS, 32'd0, 32'd0, "misses_prog_a", 32'd1);
        rd(CMD_READ_FIFO_COUNT, 32'd0, 32'd0, "fifo_peak_prog_a", 32'd0);
        rd(CMD_READ_CACHE_HITS, 32'd0, 32'd1, "hits_sel1", 32'd0);
        rd(CMD_READ_ELAPSED_CLOCK, 32'd0, 32'd0, "elapsed_prog_a", 32'(last_run));

        wr(32'd1, 32'h0000_0062);
        start_run(32'd4, 32'd4, "status_prog_a_mismatch", STATUS_REJECTED);
        finish_run("prog_a_mismatch", 4);
        rd(CMD_READ_CACHE_HITS, 32'd0, 32'd0, "hits_mismatch", 32'd0);
        rd(CMD_READ_CACHE_MISS, 32'd0, 32'd0, "misses_mismatch", 32'd1);

        // SPLIT 3; MATCH 'a'; JMP 4; MATCH 'b'; ACCEPT -- string "b" at byte 12
        wr(32'd0, 32'h4061_2003);
        wr(32'd1, 32'h4062_6004);
        wr(32'd2, 32'h0000_0000);
        wr(32'd3, 32'h0000_0062);
        start_run(32'd12, 32'd12, "status_prog_b", STATUS_ACCEPTED);
        finish_run("prog_b", 16);
        rd(CMD_READ_FIFO_COUNT, 32'd0, 32'd0, "fifo_peak_prog_b", 32'd1);
        rd(CMD_READ_FIFO_COUNT, 32'd0, 32'd1, "fifo_peak_sel1", 32'd0);
        rd(CMD_READ_CACHE_HITS, 32'd0, 32'd0, "hits_prog_b", 32'd1);
        rd(CMD_READ_CACHE_MISS, 32'd0, 32'd0, "misses_prog_b", 32'd3);
        rd(CMD_READ_ELAPSED_CLOCK, 32'd0, 32'd0, "elapsed_prog_b", 32'(last_run));

        wr(32'd20, 32'hA5A5_A5A5);
        wr(32'd0, 32'h0000_4061);
        wr(32'd1, 32'h0000_0061);
        start_run(32'd4, 32'd4, "status_write_while_running", STATUS_ACCEPTED);
        wr(32'd20, 32'h1234_5678);
        wr(32'd20, 32'h1234_5678);
        finish_run("write_while_running", 8);
        rd(CMD_READ, 32'd20, 32'd0, "word20_protected", 32'hA5A5_A5A5);

        start_run(32'd4, 32'd4, "status_reset_while_running", STATUS_IDLE);
        idle();
        idle();
        q_data.push_back('{"data_o_reset_while_running", 32'd0});
        @(posedge clk);
        #1;
        rst          = 1'b1;
        cmd_register = CMD_NOP;
        tb_rd        = 1'b1;
        tb_st        = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        tb_rd = 1'b0;
        rd(CMD_READ_ELAPSED_CLOCK, 32'd0, 32'd0, "elapsed_after_reset", 32'd0);

        repeat (4) idle();
        if (q_data.size() != 0 || q_status.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d data and %0d status entries left, expected 0",
                     q_data.size(), q_status.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cicero_axi_top.md
Name: cicero_axi_top

Overview:
Register-driven top of a single-engine regex co-processor.
- A host drives flat 32-bit registers: command, address, data-in, start/end string pointers. It reads back status and data-out.
- One on-chip memory holds both the compiled program (16-bit instructions) and the input string (bytes).
- On START, a backtracking thread engine runs the program over the string and reports ACCEPTED or REJECTED. It also exposes cycle-count, thread-FIFO peak and instruction-buffer hit/miss statistics.

Parameters:
- BB_N, 1, number of engine instances; only 1 is legal, and any other value is an elaboration error.
- CC_ID_BITS, 2, thread FIFO depth = 2**CC_ID_BITS entries.
- MEM_WORDS, 1024, depth of the 32-bit memory.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- data_in_register  in  32  write data / statistics selector
- address_register  in  32  host word address (byte address >> 2)
- start_cc_pointer_register  in  32  byte address of first string character
- end_cc_pointer_register  in  32  byte address of last string character (inclusive)
- cmd_register  in  32  command
- status_register  out  32  engine status
- data_o_register  out  32  read data / statistics

Interface note: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset:
  - status = IDLE, data_o = 0, all counters = 0, FIFO empty, instruction buffer invalid.
  - Memory contents are not cleared.
  - Reset during RUNNING returns the block to IDLE.
- Commands are level-sampled every cycle.
- CMD_WRITE:
  - mem[address] <= data_in on every cycle the command is held.
  - Ignored while RUNNING.
- CMD_READ: data_o <= mem[address] each cycle held; 1-cycle latency.
- Memory layout:
  - Instruction i occupies word i>>1; bits [15:0] when i[0]=0, bits [31:16] when i[0]=1.
  - String byte b occupies word b>>2, bits [8*b[1:0] +: 8].
- CMD_START:
  - Accepted only when not RUNNING.
  - Latches both pointers, clears the elapsed counter, FIFO, FIFO peak, hit/miss counters and instruction buffer.
  - The initial thread is pc=0, cc=start.
  - status = RUNNING from the next cycle and for at least 2 cycles.
  - ACCEPTED/REJECTED hold until the next START or reset.
- Instruction format: [15:13] opcode, [12:0] operand.
  - 0 ACCEPT: if cc == end+1, finish ACCEPTED; otherwise kill the thread.
  - 1 SPLIT: push (operand, cc) to the FIFO; continue at pc+1.
  - 2 MATCH_CHAR: if cc <= end and char == operand[7:0], then pc+1, cc+1; otherwise kill.
  - 3 JMP: pc = operand.
  - 4 END_WITHOUT_ACCEPTING: kill.
  - 5 MATCH_ANY: if cc <= end, then pc+1, cc+1; otherwise kill.
  - 6 ACCEPT_PARTIAL: finish ACCEPTED immediately.
  - 7 NOT_MATCH: if cc <= end and char != operand[7:0], then pc+1, cc+1; otherwise kill.
- Thread control:
  - On kill, pop the FIFO; if the FIFO is empty, finish REJECTED.
  - Pushing to a full FIFO finishes REJECTED.
- Instruction buffer: holds one 32-bit code word and its index.
  - A fetch hitting the buffered word increments the hits counter.
  - Otherwise it reads memory, refills the buffer and increments the misses counter.
- Latency: at most 4 cycles per executed instruction. The engine uses a second memory port, independent of the host port.
- Elapsed counter: counts cycles while RUNNING; saturates at 2**32-1.
- Statistics reads (data_o registered, 1-cycle latency):
  - READ_ELAPSED_CLOCK returns the elapsed counter.
  - READ_FIFO_COUNT returns the FIFO peak occupancy for selector 0, else 0.
  - READ_CACHE_HITS / READ_CACHE_MISS return the counters for selector 0, else 0.
- An unknown command behaves as NOP.

Decomposition:
- Shared package AXI_package: REG_WIDTH=32; CMD_NOP=0, CMD_WRITE=1, CMD_READ=2, CMD_START=3, CMD_READ_ELAPSED_CLOCK=4, CMD_READ_FIFO_COUNT=5, CMD_READ_CACHE_HITS=6, CMD_READ_CACHE_MISS=7; STATUS_IDLE=0, STATUS_RUNNING=1, STATUS_ACCEPTED=2, STATUS_REJECTED=3.
- Shared package instruction_package: INSTRUCTION_WIDTH=16 and the opcode enum.
- One sub-module, cicero_thread_fifo: depth 2**CC_ID_BITS, entries {pc, cc}, with count and peak outputs.

Test Plan:
- Write 0xDEADBEEF to word 5, then CMD_READ address 5 -> data_o = 0xDEADBEEF one cycle later; word 6 is unchanged.
- Word0 = 0x0000_4061, word1 = 0x0000_0061, START (4, 4) -> RUNNING for ≥2 cycles, then ACCEPTED; hits = 1, misses = 1, FIFO peak = 0.
- Same program with word1 = 0x0000_0062 -> REJECTED.
- Program 0x2003, 0x4061, 0x6004, 0x4062, 0x0000 with string "b" -> ACCEPTED; FIFO peak = 1, hits = 1, misses = 3.
- After any run, READ_ELAPSED_CLOCK -> nonzero value equal to the RUNNING cycle count; a second START clears it.
- Assert rst while RUNNING -> status = IDLE next cycle and data_o = 0; CMD_WRITE while RUNNING -> memory unchanged.
